janela_interp: RTL and testbench
================================

# janela_interp

Upsample-by-2 tap window generator that sits directly upstream of the 7-tap interpolation filter `filtrodown`. It accepts signed input samples through a valid/ready handshake and zero-stuffs them at ratio 2, applying ×2 gain compensation. It presents the seven most recent upsampled values as parallel taps `tap0`..`tap6`, aligned to the filter's `in0`..`in6`, with a valid/ready handshake toward the consumer that registers the filter output.

## Interface
- `DATA_WIDTH`, 8, width of input samples; the taps are DATA_WIDTH+2 bits wide, matching the filter's inputs.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `limpa`  in  1  synchronous clear; flushes the window.
- `in_data`  in  DATA_WIDTH  signed input sample.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `tap0`..`tap6`  out  DATA_WIDTH+2 each  signed window; `tap0` is newest, `tap6` is oldest.
- `out_valid`  out  1  the window is full and the taps are valid.
- `out_ready`  in  1  the downstream consumer takes the current window.

## Operation
- **Registers:** seven taps; fill counter `cnt` (0..7, saturating); phase `fase` ∈ {AMOSTRA, ZERO}; `out_valid`.
- **Shift:** `tap[k]` ← `tap[k-1]` for k=1..6; `tap0` ← new value.
- **Advance condition:** `adv = !out_valid || out_ready`.
- **`in_ready`:** equals `(fase==AMOSTRA) && adv && !rst && !limpa`. It is combinational.
- **AMOSTRA phase, `in_valid && in_ready`:**
  - Shift in `sext(in_data)<<1`: sign-extend to DATA_WIDTH+2 bits, then shift left by 1.
  - `cnt` ← min(`cnt`+1, 7); `fase` ← ZERO.
- **ZERO phase, `adv`:**
  - Shift in 0.
  - `cnt` ← min(`cnt`+1, 7); `fase` ← AMOSTRA.
- **`out_valid` update on any shift:** `out_valid` ← (new `cnt` == 7). Windows before the counter reaches 7 shift silently.
- **No shift, `out_ready` high:** `out_valid` ← 0.
- **No shift, `out_ready` low:** everything holds.
- **Gain compensation:** the ×2 restores unity DC gain. Zero-stuffing halves the gain, and the filter's coefficient sum is 64 with a >>6 output. The scaled value always fits: −2^DATA_WIDTH .. 2^DATA_WIDTH−2.
- **`limpa` (priority over everything except `rst`):**
  - Next edge clears all taps, `cnt`, and `out_valid`; `fase` ← AMOSTRA.
  - An input offered in that cycle is not accepted.
- **`rst`:** same cleared state, applied immediately and asynchronously.
- **Reset values:**
  - `tap0`..`tap6` = 0; `out_valid` = 0; `fase` = AMOSTRA; `cnt` = 0.
  - `in_ready` = 0 while `rst` is high.

## Timing
- **Latency:** a sample accepted at edge N appears on `tap0` after edge N (registered). The zero then enters at the first later edge with `adv` true.
- **Throughput:** with `out_ready` tied high, at most one input per 2 cycles. `in_ready` pattern is 1,0,1,0…
- **Fill:** the first `out_valid` rises on the edge that accepts the 4th sample after reset or `limpa`. That is 7 shifts: s,0,s,0,s,0,s.
- **Steady state:** after fill, `out_valid` stays high every cycle while the upstream keeps up. If in AMOSTRA with `in_valid` low and `out_ready` high, `out_valid` drops until the next accept.
- **Backpressure:** with `out_valid`=1 and `out_ready`=0:
  - Taps, `fase`, and `cnt` hold.
  - `in_ready`=0, and the ZERO phase does not advance.
- **Handshake rules:**
  - Upstream must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.
  - `in_valid` may drop without a transfer.
- **`rst` mid-operation:** outputs clear without a clock edge. Any partially filled window is discarded.
- **Simultaneous `limpa` and `in_valid`:** `limpa` wins.

## Test plan
- **Fill:** after reset, `out_ready`=1, feed 10, 20, 30, 40.
  - `out_valid` first goes high after the 40 is accepted, with taps (0..6) = 80, 0, 60, 0, 40, 0, 20.
  - Next cycle: 0, 80, 0, 60, 0, 40, 0, with `out_valid`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles while `out_valid`=1 and `in_valid`=1.
  - Taps are frozen and `in_ready`=0 throughout.
  - Releasing `out_ready` advances exactly one shift per cycle.
- **Extremes (DATA_WIDTH=8):** in_data=−128 → `tap0`=−256 (10'h300); in_data=127 → `tap0`=254.
- **Continuous input:** `in_valid` held high and `out_ready`=1 → `in_ready` toggles 1,0. 8 samples take 16 cycles, and the taps alternate sample/zero.
- **`limpa`:** pulse `limpa` for one cycle mid-stream with `out_valid`=1.
  - Next cycle: all taps 0, `out_valid`=0, `fase`=AMOSTRA.
  - 4 new samples are required before `out_valid` rises again.
- **Asynchronous reset:** assert `rst` between clock edges while `out_valid`=1 → taps and `out_valid` clear immediately and `in_ready`=0. After deassertion, the first accepted sample lands in `tap0` with `out_valid`=0.

Source files
------------

// File: rtl/janela_interp_if.sv
// Handshake bundle for janela_interp: upstream sample port plus the
// seven-tap window presented to the downstream filter.
interface janela_interp_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH+1:0] tap0;
  logic signed [DATA_WIDTH+1:0] tap1;
  logic signed [DATA_WIDTH+1:0] tap2;
  logic signed [DATA_WIDTH+1:0] tap3;
  logic signed [DATA_WIDTH+1:0] tap4;
  logic signed [DATA_WIDTH+1:0] tap5;
  logic signed [DATA_WIDTH+1:0] tap6;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, tap0, tap1, tap2, tap3, tap4, tap5, tap6, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, tap0, tap1, tap2, tap3, tap4, tap5, tap6, out_valid
  );
endinterface

// File: rtl/janela_interp.sv
// Upsample-by-2 tap window: zero-stuffs input samples (x2 gain) and presents
// the seven newest upsampled values to the 7-tap interpolation filter.
module janela_interp #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           limpa,
  janela_interp_if.slave bus
);
  localparam int TW = DATA_WIDTH + 2;

  typedef enum logic {AMOSTRA = 1'b0, ZERO = 1'b1} fase_t;

  logic signed [TW-1:0] tap_p0 [7];
  logic [2:0]           cnt;
  fase_t                fase;
  logic                 vld_p0;
  logic                 adv;
  logic                 aceita;
  logic                 desloca;
  logic signed [TW-1:0] novo;

  // x2 restores unity DC gain lost to zero-stuffing; the result always fits TW bits
  function automatic logic signed [TW-1:0] ganho(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [TW-1:0] ext;
    ext = {{2{x[DATA_WIDTH-1]}}, x};
    return ext <<< 1;
  endfunction

  function automatic logic [2:0] cnt_sat(input logic [2:0] c);
    return (c == 3'd7) ? 3'd7 : c + 3'd1;
  endfunction

  assign adv          = !vld_p0 || bus.out_ready;
  assign bus.in_ready = (fase == AMOSTRA) && adv && !rst && !limpa;
  assign aceita       = bus.in_valid && bus.in_ready;
  assign desloca      = aceita || ((fase == ZERO) && adv);
  assign novo         = (fase == AMOSTRA) ? ganho(bus.in_data) : '0;

  // Stage p0: tap window, fill counter, phase and output valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) tap_p0[k] <= '0;
      cnt    <= '0;
      fase   <= AMOSTRA;
      vld_p0 <= 1'b0;
    end else if (limpa) begin
      for (int k = 0; k < 7; k++) tap_p0[k] <= '0;
      cnt    <= '0;
      fase   <= AMOSTRA;
      vld_p0 <= 1'b0;
    end else if (desloca) begin
      for (int k = 6; k > 0; k--) tap_p0[k] <= tap_p0[k-1];
      tap_p0[0] <= novo;
      cnt       <= cnt_sat(cnt);
      fase      <= (fase == AMOSTRA) ? ZERO : AMOSTRA;
      vld_p0    <= (cnt_sat(cnt) == 3'd7);
    end else if (bus.out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign bus.tap0      = tap_p0[0];
  assign bus.tap1      = tap_p0[1];
  assign bus.tap2      = tap_p0[2];
  assign bus.tap3      = tap_p0[3];
  assign bus.tap4      = tap_p0[4];
  assign bus.tap5      = tap_p0[5];
  assign bus.tap6      = tap_p0[6];
  assign bus.out_valid = vld_p0;
endmodule

// File: tb/tb_janela_interp.sv
// Directed bench for janela_interp: vector table for fill, backpressure,
// extremes and limpa, plus hand sequences for async reset and streaming.
module tb_janela_interp;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic limpa;
  int   tests = 0;
  int   fails = 0;

  janela_interp_if #(.DATA_WIDTH(DW)) bus ();

  janela_interp #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .limpa (limpa),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             lim;
    logic             iv;
    logic signed [7:0] data;
    logic             ordy;
    int               eir;
    int               eov;
    int t0, t1, t2, t3, t4, t5, t6;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lim, input logic iv, input int data, input logic ordy,
                     input int eir, input int eov,
                     input int t0, input int t1, input int t2, input int t3,
                     input int t4, input int t5, input int t6);
    vec_t v;
    v.lim = lim; v.iv = iv; v.data = 8'(data); v.ordy = ordy;
    v.eir = eir; v.eov = eov;
    v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3; v.t4 = t4; v.t5 = t5; v.t6 = t6;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_taps(input string nm, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int e5, input int e6);
    chk({nm, ".tap0"}, int'(bus.tap0), e0);
    chk({nm, ".tap1"}, int'(bus.tap1), e1);
    chk({nm, ".tap2"}, int'(bus.tap2), e2);
    chk({nm, ".tap3"}, int'(bus.tap3), e3);
    chk({nm, ".tap4"}, int'(bus.tap4), e4);
    chk({nm, ".tap5"}, int'(bus.tap5), e5);
    chk({nm, ".tap6"}, int'(bus.tap6), e6);
  endtask

  initial begin
    int acc;
    rst = 1'b1; limpa = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

    // fill: 10,20,30,40
    add(0,1, 10,1, 1,0,  20,  0,   0,   0,   0,  0,  0);
    add(0,1, 20,1, 0,0,   0, 20,   0,   0,   0,  0,  0);
    add(0,1, 20,1, 1,0,  40,  0,  20,   0,   0,  0,  0);
    add(0,1, 30,1, 0,0,   0, 40,   0,  20,   0,  0,  0);
    add(0,1, 30,1, 1,0,  60,  0,  40,   0,  20,  0,  0);
    add(0,1, 40,1, 0,0,   0, 60,   0,  40,   0, 20,  0);
    add(0,1, 40,1, 1,1,  80,  0,  60,   0,  40,  0, 20);
    add(0,1, 50,1, 0,1,   0, 80,   0,  60,   0, 40,  0);
    // backpressure for 5 cycles, window frozen
    for (int i = 0; i < 5; i++)
      add(0,1, 50,0, 0,1, 0, 80, 0, 60, 0, 40, 0);
    add(0,1, 50,1, 1,1, 100,  0,  80,   0,  60,  0, 40);
    // extremes
    add(0,1,-128,1, 0,1,   0,100,   0,  80,   0, 60,  0);
    add(0,1,-128,1, 1,1,-256,  0, 100,   0,  80,  0, 60);
    add(0,1, 127,1, 0,1,   0,-256,  0, 100,   0, 80,  0);
    add(0,1, 127,1, 1,1, 254,  0,-256,   0, 100,  0, 80);
    add(0,0,   0,1, 0,1,   0,254,   0,-256,   0,100,  0);
    // starved in AMOSTRA: out_valid drops, taps hold
    add(0,0,   0,1, 1,0,   0,254,   0,-256,   0,100,  0);
    add(0,1,   5,1, 1,1,  10,  0, 254,   0,-256,  0,100);
    add(0,0,   0,1, 0,1,   0, 10,   0, 254,   0,-256, 0);
    // limpa with an offered input: not accepted, window flushed
    add(1,1,   6,1, 0,0,   0,  0,   0,   0,   0,  0,  0);
    add(0,1,   6,1, 1,0,  12,  0,   0,   0,   0,  0,  0);
    add(0,1,   7,1, 0,0,   0, 12,   0,   0,   0,  0,  0);
    add(0,1,   7,1, 1,0,  14,  0,  12,   0,   0,  0,  0);
    add(0,1,   8,1, 0,0,   0, 14,   0,  12,   0,  0,  0);
    add(0,1,   8,1, 1,0,  16,  0,  14,   0,  12,  0,  0);
    add(0,1,   9,1, 0,0,   0, 16,   0,  14,   0, 12,  0);
    add(0,1,   9,1, 1,1,  18,  0,  16,   0,  14,  0, 12);

    @(posedge clk);
    #2;
    chk("rst.in_ready", int'(bus.in_ready), 0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk_taps("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      limpa = vecs[i].lim;
      bus.in_valid = vecs[i].iv;
      bus.in_data = vecs[i].data;
      bus.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), int'(bus.in_ready), vecs[i].eir);
      @(negedge clk);
      chk($sformatf("v%0d.out_valid", i), int'(bus.out_valid), vecs[i].eov);
      chk_taps($sformatf("v%0d", i), vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].t3,
               vecs[i].t4, vecs[i].t5, vecs[i].t6);
    end

    // asynchronous reset between edges while out_valid=1
    limpa = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.out_valid", int'(bus.out_valid), 0);
    chk("arst.in_ready", int'(bus.in_ready), 0);
    chk_taps("arst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'sd3;
    #1 chk("arst.first.in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    chk("arst.first.out_valid", int'(bus.out_valid), 0);
    chk_taps("arst.first", 6, 0, 0, 0, 0, 0, 0);

    // continuous input: flush, then 8 samples over 16 cycles
    bus.in_valid = 1'b0; limpa = 1'b1;
    @(negedge clk);
    limpa = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'(acc + 1);
      #1;
      chk($sformatf("cont%0d.in_ready", i), int'(bus.in_ready), (i % 2 == 0) ? 1 : 0);
      if (bus.in_ready) acc++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("cont.accepted", acc, 8);
    chk("cont.out_valid", int'(bus.out_valid), 1);
    chk_taps("cont", 0, 16, 0, 14, 0, 12, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
